// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic slave between N_MASTERS masters.
// Optional bus watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_bus_arbiter #(
    parameter int WB_DATA_WIDTH  = 32,
    parameter int WB_ADDR_WIDTH  = 11,
    parameter int GRANULARITY    = 8,
    parameter int N_MASTERS      = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [N_MASTERS-1:0]                 m_cyc_i,
    input  logic [N_MASTERS-1:0]                 m_stb_i,
    input  logic [N_MASTERS-1:0]                 m_we_i,
    input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0]   m_adr_i,
    input  logic [N_MASTERS*WB_DATA_WIDTH-1:0]   m_dat_i,
    input  logic [N_MASTERS*(WB_DATA_WIDTH/GRANULARITY)-1:0] m_sel_i,
    output logic [WB_DATA_WIDTH-1:0]             m_dat_o,
    output logic [N_MASTERS-1:0]                 m_ack_o,
    output logic [N_MASTERS-1:0]                 m_err_o,
    output logic                                 s_cyc_o,
    output logic                                 s_stb_o,
    output logic                                 s_we_o,
    output logic [WB_ADDR_WIDTH-1:0]             s_adr_o,
    output logic [WB_DATA_WIDTH-1:0]             s_dat_o,
    output logic [(WB_DATA_WIDTH/GRANULARITY)-1:0] s_sel_o,
    input  logic [WB_DATA_WIDTH-1:0]             s_dat_i,
    input  logic                                 s_ack_i,
    output logic [N_MASTERS-1:0]                 grant_o
);

    localparam int SEL_W = WB_DATA_WIDTH / GRANULARITY;
    localparam int IDX_W = $clog2(N_MASTERS);

    if (N_MASTERS < 2 || N_MASTERS > 4 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("wb_bus_arbiter: illegal N_MASTERS or TIMEOUT_CYCLES");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     winner;
    logic                 found;
    logic                 timeout;

    logic                     g_cyc, g_stb, g_we;
    logic [WB_ADDR_WIDTH-1:0] g_adr;
    logic [WB_DATA_WIDTH-1:0] g_dat;
    logic [SEL_W-1:0]         g_sel;

    // grant_q is all-zero outside BUSY, so the mux naturally drives zeros when idle
    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_adr = '0;
        g_dat = '0;
        g_sel = '0;
        for (int j = 0; j < N_MASTERS; j++) begin
            if (grant_q[j]) begin
                g_cyc = m_cyc_i[j];
                g_stb = m_stb_i[j];
                g_we  = m_we_i[j];
                g_adr = m_adr_i[j*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
                g_dat = m_dat_i[j*WB_DATA_WIDTH +: WB_DATA_WIDTH];
                g_sel = m_sel_i[j*SEL_W +: SEL_W];
            end
        end
    end

    // Round-robin pick: first requester at or above ptr, else first one below it
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int j = 0; j < N_MASTERS; j++) begin
            if (!found && m_cyc_i[j] && j >= int'(ptr_q)) begin
                found  = 1'b1;
                winner = IDX_W'(j);
            end
        end
        for (int j = 0; j < N_MASTERS; j++) begin
            if (!found && m_cyc_i[j] && j < int'(ptr_q)) begin
                found  = 1'b1;
                winner = IDX_W'(j);
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] timer_q, timer_d;
    logic        stalled;

    always_comb begin
        stalled = (state_q == BUSY) && g_stb && !s_ack_i;
        timeout = stalled && (timer_q == 16'(TIMEOUT_CYCLES - 1));
        timer_d = (stalled && !timeout) ? timer_q + 16'd1 : 16'd0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) timer_q <= '0;
        else       timer_q <= timer_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d         = BUSY;
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    ptr_d           = (winner == IDX_W'(N_MASTERS - 1)) ? '0 : winner + 1'b1;
                end
            end
            BUSY: begin
                if (timeout || !g_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        s_cyc_o = g_cyc && !timeout;
        s_stb_o = g_stb && !timeout;
        s_we_o  = g_we;
        s_adr_o = g_adr;
        s_dat_o = g_dat;
        s_sel_o = g_sel;
        m_dat_o = s_dat_i;
        grant_o = grant_q;
        for (int j = 0; j < N_MASTERS; j++) begin
            m_ack_o[j] = grant_q[j] && s_ack_i && m_cyc_i[j] && m_stb_i[j];
            m_err_o[j] = grant_q[j] && timeout;
        end
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Scoreboard bench for wb_bus_arbiter with two masters and a short watchdog limit;
// expectations follow WB_ARB_TIMEOUT_EN when it is defined.
module tb_wb_bus_arbiter;

    localparam int DW = 32;
    localparam int AW = 11;
    localparam int SW = 4;
    localparam int NM = 2;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [NM-1:0]   m_cyc_i, m_stb_i, m_we_i;
    logic [NM*AW-1:0] m_adr_i;
    logic [NM*DW-1:0] m_dat_i;
    logic [NM*SW-1:0] m_sel_i;
    logic [DW-1:0]   m_dat_o;
    logic [NM-1:0]   m_ack_o, m_err_o, grant_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i;

    typedef struct packed {
        logic [1:0] grant;
        logic       scyc;
        logic       sstb;
        logic [1:0] ack;
        logic [1:0] err;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    wb_bus_arbiter #(
        .WB_DATA_WIDTH (DW),
        .WB_ADDR_WIDTH (AW),
        .GRANULARITY   (8),
        .N_MASTERS     (NM),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .m_cyc_i(m_cyc_i),
        .m_stb_i(m_stb_i),
        .m_we_i (m_we_i),
        .m_adr_i(m_adr_i),
        .m_dat_i(m_dat_i),
        .m_sel_i(m_sel_i),
        .m_dat_o(m_dat_o),
        .m_ack_o(m_ack_o),
        .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o),
        .s_stb_o(s_stb_o),
        .s_we_o (s_we_o),
        .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o),
        .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i),
        .grant_o(grant_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, queue what the arbiter must show, then compare
    task automatic applyStimulus(input logic [1:0] cyc, input logic [1:0] stb, input logic ack,
                                 input logic rst, input logic [1:0] eGrant, input logic eCyc,
                                 input logic eStb, input logic [1:0] eAck, input logic [1:0] eErr);
        exp_t e;
        @(posedge clk_i);
        #1;
        m_cyc_i = cyc;
        m_stb_i = stb;
        s_ack_i = ack;
        rst_i   = rst;
        expQ.push_back('{grant: eGrant, scyc: eCyc, sstb: eStb, ack: eAck, err: eErr});
        #2;
        e = expQ.pop_front();
        checkOutput("grant_o", 32'(grant_o), 32'(e.grant));
        checkOutput("s_cyc_o", 32'(s_cyc_o), 32'(e.scyc));
        checkOutput("s_stb_o", 32'(s_stb_o), 32'(e.sstb));
        checkOutput("m_ack_o", 32'(m_ack_o), 32'(e.ack));
        checkOutput("m_err_o", 32'(m_err_o), 32'(e.err));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] rd;
        rst_i   = 1'b1;
        m_cyc_i = '0;
        m_stb_i = '0;
        m_we_i  = 2'b01;
        m_adr_i = {11'h7AA, 11'h123};
        m_dat_i = {32'h1234_5678, 32'h0000_BEEF};
        m_sel_i = {4'b1100, 4'b0011};
        s_dat_i = '0;
        s_ack_i = 1'b0;

        $display("[TB] reset");
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        checkOutput("rst_s_adr", 32'(s_adr_o), 32'h0);
        checkOutput("rst_s_we", 32'(s_we_o), 32'h0);

        $display("[TB] single master");
        applyStimulus(2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        applyStimulus(2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00);
        checkOutput("m0_s_adr", 32'(s_adr_o), 32'h123);
        checkOutput("m0_s_dat", s_dat_o, 32'h0000_BEEF);
        checkOutput("m0_s_sel", 32'(s_sel_o), 32'h3);
        checkOutput("m0_s_we", 32'(s_we_o), 32'h1);
        applyStimulus(2'b01, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 2'b01, 2'b00);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);

        applyStimulus(2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);

        $display("[TB] contention");
        for (int r = 0; r < 2; r++) begin
            applyStimulus(2'b11, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
            applyStimulus(2'b11, 2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 2'b01, 2'b00);
            applyStimulus(2'b10, 2'b10, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00);
            applyStimulus(2'b11, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
            applyStimulus(2'b11, 2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 2'b10, 2'b00);
            checkOutput("m1_s_adr", 32'(s_adr_o), 32'h7AA);
            checkOutput("m1_s_dat", s_dat_o, 32'h1234_5678);
            checkOutput("m1_s_we", 32'(s_we_o), 32'h0);
            applyStimulus(2'b01, 2'b01, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00);
        end

        $display("[TB] burst hold");
        applyStimulus(2'b10, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        for (int b = 0; b < 3; b++) begin
            applyStimulus(2'b11, 2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 2'b10, 2'b00);
        end
        applyStimulus(2'b01, 2'b01, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00);
        applyStimulus(2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);

        $display("[TB] reset mid-transfer");
        applyStimulus(2'b01, 2'b01, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00);
        applyStimulus(2'b11, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        applyStimulus(2'b11, 2'b11, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00);

        $display("[TB] stalled slave");
        applyStimulus(2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        for (int s = 0; s < 3; s++) begin
            applyStimulus(2'b11, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00);
        end
`ifdef WB_ARB_TIMEOUT_EN
        applyStimulus(2'b11, 2'b01, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b01);
        applyStimulus(2'b11, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        applyStimulus(2'b11, 2'b01, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 2'b00, 2'b00);
`else
        for (int s = 0; s < 3; s++) begin
            applyStimulus(2'b11, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00);
        end
`endif

        $display("[TB] read data broadcast");
        for (int k = 0; k < 3; k++) begin
            rd      = $urandom;
            s_dat_i = rd;
            #1;
            checkOutput("m_dat_o", m_dat_o, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
